axi_id_arbiter: RTL

//  Merges the instruction-side read master and the data-side master (read + write, from the
//  d-side cache/uncached arbiter) into one AXI master port toward the bus bridge.
//  One read transaction and one write transaction may be in flight at a time.

---
 rtl/axi_id_arbiter_pkg.sv | 32 +++
 rtl/axi_id_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_id_arbiter_pkg.sv
// Shared encodings for the i/d AXI master merge: burst type, transaction IDs,
// read/write FSM states and the latched address-channel request.
package axi_id_arbiter_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] I_ID_DEFAULT   = 4'd0;
  localparam logic [3:0] D_ID_DEFAULT   = 4'd1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ax_req_t;

endpackage

// File: rtl/axi_id_arbiter.sv
// Merges the i-side read master and the d-side read/write master onto one AXI
// master port; one read and one write in flight, with optional read-after-write hold.
module axi_id_arbiter
  import axi_id_arbiter_pkg::*;
#(
  parameter bit         D_PRIORITY = 1'b1,
  parameter bit         RAW_HOLD   = 1'b1,
  parameter logic [3:0] I_ID       = I_ID_DEFAULT,
  parameter logic [3:0] D_ID       = D_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [3:0]  m_wid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [3:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  rd_state_e rd_state_q, rd_state_d;
  owner_e    owner_q, owner_d;
  owner_e    rr_last_q, rr_last_d;
  ax_req_t   ar_q, ar_d;

  wr_state_e wr_state_q, wr_state_d;
  ax_req_t   aw_q, aw_d;
  logic      aw_done_q, aw_done_d;
  logic      w_done_q, w_done_d;

  logic raw_block;
  logic d_cand;
  logic grant_d;
  logic grant_i;
  logic to_i;
  logic to_d;
  logic w_open;
  logic unused_resp;

  // Routing trusts the owner register, so returned IDs and responses are not needed.
  assign unused_resp = ^{m_rid, m_rresp, m_bid, m_bresp};

  // Grants are suppressed while reset is asserted so no upstream handshake is lost.
  always_comb begin
    raw_block = RAW_HOLD && (wr_state_q != W_IDLE);
    d_cand    = d_arvalid && !raw_block;
    grant_d   = (rd_state_q == R_IDLE) && !rst && d_cand &&
                (D_PRIORITY || !i_arvalid || (rr_last_q == OWN_I));
    grant_i   = (rd_state_q == R_IDLE) && !rst && i_arvalid && !grant_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    ar_d       = ar_q;
    case (rd_state_q)
      R_IDLE: begin
        if (grant_d) begin
          ar_d       = '{addr: d_araddr, len: d_arlen, size: d_arsize};
          owner_d    = OWN_D;
          rd_state_d = R_ADDR;
        end else if (grant_i) begin
          ar_d       = '{addr: i_araddr, len: i_arlen, size: i_arsize};
          owner_d    = OWN_I;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (m_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (m_rvalid && m_rready && m_rlast) begin
          rr_last_d  = owner_q;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      owner_q    <= OWN_I;
      rr_last_q  <= OWN_I;
      ar_q       <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      ar_q       <= ar_d;
    end
  end

  assign i_arready = grant_i;
  assign d_arready = grant_d;
  assign m_arvalid = (rd_state_q == R_ADDR);
  assign m_arid    = (owner_q == OWN_D) ? D_ID : I_ID;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = AXI_BURST_INCR;

  assign to_i     = (rd_state_q == R_DATA) && (owner_q == OWN_I);
  assign to_d     = (rd_state_q == R_DATA) && (owner_q == OWN_D);
  assign i_rvalid = to_i && m_rvalid;
  assign i_rlast  = to_i && m_rlast;
  assign i_rdata  = m_rdata;
  assign d_rvalid = to_d && m_rvalid;
  assign d_rlast  = to_d && m_rlast;
  assign d_rdata  = m_rdata;
  assign m_rready = (to_i && i_rready) || (to_d && d_rready);

  // AW and W complete independently inside W_XFER; either may finish first.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_d       = aw_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      W_IDLE: begin
        if (d_awvalid) begin
          aw_d       = '{addr: d_awaddr, len: d_awlen, size: d_awsize};
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_XFER;
        end
      end
      W_XFER: begin
        if (m_awvalid && m_awready) aw_done_d = 1'b1;
        if (m_wvalid && m_wready && d_wlast) w_done_d = 1'b1;
        if (aw_done_q && w_done_q) wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (m_bvalid && d_bready) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      aw_q       <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_q       <= aw_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign w_open    = (wr_state_q == W_XFER) && !w_done_q;
  assign d_awready = (wr_state_q == W_IDLE) && d_awvalid && !rst;
  assign m_awvalid = (wr_state_q == W_XFER) && !aw_done_q;
  assign m_awid    = D_ID;
  assign m_awaddr  = aw_q.addr;
  assign m_awlen   = aw_q.len;
  assign m_awsize  = aw_q.size;
  assign m_awburst = AXI_BURST_INCR;

  assign m_wid    = D_ID;
  assign m_wdata  = d_wdata;
  assign m_wstrb  = d_wstrb;
  assign m_wlast  = w_open && d_wlast;
  assign m_wvalid = w_open && d_wvalid;
  assign d_wready = w_open && m_wready;

  assign m_bready = (wr_state_q == W_RESP) && d_bready;
  assign d_bvalid = (wr_state_q == W_RESP) && m_bvalid;

endmodule
